// File: rtl/sdp_y_pkg.sv
// Shared definitions for the SDP Y datapath stages: lane/product widths,
// saturation limits and the shift clamp helper.
package sdp_y_pkg;

  localparam int LANE_W    = 32;
  localparam int PROD_W    = 48;
  localparam int SHIFT_W   = 6;
  localparam int SHIFT_MAX = 47;

  localparam logic [LANE_W-1:0] SAT_POS = 32'h7FFF_FFFF;
  localparam logic [LANE_W-1:0] SAT_NEG = 32'h8000_0000;

  typedef logic signed [LANE_W-1:0] lane_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic        [SHIFT_W-1:0] shift_t;

  // Shifts beyond the product width carry no information; pin them at the top.
  function automatic shift_t clamp_shift(input shift_t s);
    return (s > shift_t'(SHIFT_MAX)) ? shift_t'(SHIFT_MAX) : s;
  endfunction

endpackage

// File: rtl/sdp_y_mul_stage_if.sv
// Data/operand/result channels of the Y multiply stage. The slave modport is
// the stage itself; the master modport is the surrounding ALU/LUT side.
interface sdp_y_mul_stage_if #(
  parameter int LANES = 4,
  parameter int OP_W  = 16
);
  import sdp_y_pkg::*;

  logic [LANES*LANE_W-1:0] chn_mul_in_rsc_z;
  logic                    chn_mul_in_rsc_vz;
  logic                    chn_mul_in_rsc_lz;

  logic [LANES*OP_W-1:0]   chn_mul_op_rsc_z;
  logic                    chn_mul_op_rsc_vz;
  logic                    chn_mul_op_rsc_lz;

  logic [LANES*LANE_W-1:0] chn_mul_out_rsc_z;
  logic                    chn_mul_out_rsc_lz;
  logic                    chn_mul_out_rsc_vz;

  logic                    cfg_mul_rsc_triosy_lz;

  modport slave (
    input  chn_mul_in_rsc_z, chn_mul_in_rsc_vz,
    output chn_mul_in_rsc_lz,
    input  chn_mul_op_rsc_z, chn_mul_op_rsc_vz,
    output chn_mul_op_rsc_lz,
    output chn_mul_out_rsc_z, chn_mul_out_rsc_lz,
    input  chn_mul_out_rsc_vz,
    output cfg_mul_rsc_triosy_lz
  );

  modport master (
    output chn_mul_in_rsc_z, chn_mul_in_rsc_vz,
    input  chn_mul_in_rsc_lz,
    output chn_mul_op_rsc_z, chn_mul_op_rsc_vz,
    input  chn_mul_op_rsc_lz,
    input  chn_mul_out_rsc_z, chn_mul_out_rsc_lz,
    output chn_mul_out_rsc_vz,
    input  cfg_mul_rsc_triosy_lz
  );

endinterface

// File: rtl/sdp_y_mul_lane.sv
// One lane of the Y multiply stage: round-half-up arithmetic right shift of
// the registered product followed by 32-bit saturation, or raw pass-through.
module sdp_y_mul_lane
  import sdp_y_pkg::*;
#(
  parameter int P_W = PROD_W
) (
  input  logic signed [P_W-1:0] prod,
  input  lane_t                 raw,
  input  shift_t                shift,
  input  logic                  pass,
  output lane_t                 res,
  output logic                  sat
);

  // One guard bit so the rounding increment can never wrap the product.
  logic signed [P_W:0] rnd;
  logic signed [P_W:0] sum;
  logic signed [P_W:0] shifted;
  logic                ovf;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the branches below can leave a latch behind.
    rnd = '0;
    res = '0;
    sat = 1'b0;
    if (shift != '0) rnd[shift - 1'b1] = 1'b1;
    sum     = {prod[P_W-1], prod} + rnd;
    shifted = sum >>> shift;
    // Out of 32-bit range whenever the bits above the lane sign disagree.
    ovf = (shifted[P_W:LANE_W-1] != {(P_W-LANE_W+2){shifted[P_W]}});
    if (pass) begin
      res = raw;
    end else if (ovf) begin
      res = shifted[P_W] ? SAT_NEG : SAT_POS;
      sat = 1'b1;
    end else begin
      res = shifted[LANE_W-1:0];
    end
  end

endmodule

// File: rtl/sdp_y_mul_stage.sv
// Y datapath multiply stage: S1 registers per-lane products, S2 registers the
// shifted/saturated result; valid/ready backpressure and a saturation counter.
// Optional macro SDP_Y_MUL_PRELU_EN adds cfg_mul_prelu (non-negative lanes pass).
module sdp_y_mul_stage
  import sdp_y_pkg::*;
#(
  parameter int LANES = 4,
  parameter int OP_W  = 16,
  parameter int CNT_W = 32
) (
  input  logic                nvdla_core_clk,
  input  logic                nvdla_core_rst,
  sdp_y_mul_stage_if.slave    bus,
  input  logic                cfg_mul_bypass,
  input  logic                cfg_mul_src,
  input  logic [OP_W-1:0]     cfg_mul_op,
  input  logic [SHIFT_W-1:0]  cfg_mul_shift,
`ifdef SDP_Y_MUL_PRELU_EN
  input  logic                cfg_mul_prelu,
`endif
  output logic [CNT_W-1:0]    sat_cnt
);

  localparam int P_W   = LANE_W + OP_W;
  localparam int ADD_W = $clog2(LANES + 1);

  // Handshake
  logic en1, en2, accept;

  // Input lane views and operand selection
  lane_t                 lane_x  [LANES];
  logic signed [OP_W-1:0] op_sel [LANES];
  logic signed [P_W-1:0]  mul    [LANES];

  // S1 registers
  logic                   s1_valid;
  logic                   s1_bypass;
  shift_t                 s1_shift;
  logic signed [P_W-1:0]  s1_prod [LANES];
  lane_t                  s1_raw  [LANES];
`ifdef SDP_Y_MUL_PRELU_EN
  logic                   s1_prelu;
`endif

  // Lane results feeding S2
  logic                    lane_pass [LANES];
  lane_t                   lane_res  [LANES];
  logic                    lane_sat  [LANES];
  logic [LANES*LANE_W-1:0] s2_next;
  logic [ADD_W-1:0]        sat_add;
  logic [CNT_W:0]          cnt_sum;

  // S2 registers
  logic                    s2_valid;
  logic [LANES*LANE_W-1:0] s2_data;

  assign en2    = !s2_valid | bus.chn_mul_out_rsc_vz;
  assign en1    = !s1_valid | en2;
  // With the operand channel selected, data and operand move only together.
  assign accept = !nvdla_core_rst & en1 & bus.chn_mul_in_rsc_vz &
                  (!cfg_mul_src | bus.chn_mul_op_rsc_vz);

  assign bus.chn_mul_in_rsc_lz     = cfg_mul_src ? accept : (!nvdla_core_rst & en1);
  assign bus.chn_mul_op_rsc_lz     = cfg_mul_src & accept;
  assign bus.chn_mul_out_rsc_lz    = !nvdla_core_rst & s2_valid;
  assign bus.chn_mul_out_rsc_z     = s2_data;
  assign bus.cfg_mul_rsc_triosy_lz = bus.chn_mul_out_rsc_lz & bus.chn_mul_out_rsc_vz;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign lane_x[i] = bus.chn_mul_in_rsc_z[LANE_W*i +: LANE_W];
    assign op_sel[i] = cfg_mul_src ? bus.chn_mul_op_rsc_z[OP_W*i +: OP_W] : cfg_mul_op;
    assign mul[i]    = P_W'(lane_x[i]) * P_W'(op_sel[i]);

`ifdef SDP_Y_MUL_PRELU_EN
    assign lane_pass[i] = s1_bypass | (s1_prelu & ~s1_raw[i][LANE_W-1]);
`else
    assign lane_pass[i] = s1_bypass;
`endif

    sdp_y_mul_lane #(.P_W(P_W)) u_lane (
      .prod  (s1_prod[i]),
      .raw   (s1_raw[i]),
      .shift (s1_shift),
      .pass  (lane_pass[i]),
      .res   (lane_res[i]),
      .sat   (lane_sat[i])
    );

    assign s2_next[LANE_W*i +: LANE_W] = lane_res[i];
  end

  always_comb begin
    sat_add = '0;
    for (int i = 0; i < LANES; i++) sat_add = sat_add + ADD_W'(lane_sat[i]);
    cnt_sum = {1'b0, sat_cnt} + (CNT_W+1)'(sat_add);
  end

  // S1: capture products and per-beat configuration on accept.
  always_ff @(posedge nvdla_core_clk) begin
    // NOTE: pipeline data arrays are cleared too, so a dropped beat leaves no
    // stale value behind after reset.
    if (nvdla_core_rst) begin
      s1_valid  <= 1'b0;
      s1_bypass <= 1'b0;
      s1_shift  <= '0;
`ifdef SDP_Y_MUL_PRELU_EN
      s1_prelu  <= 1'b0;
`endif
      for (int i = 0; i < LANES; i++) begin
        s1_prod[i] <= '0;
        s1_raw[i]  <= '0;
      end
    end else if (en1) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      s1_valid <= accept;
      if (accept) begin
        s1_bypass <= cfg_mul_bypass;
        s1_shift  <= clamp_shift(cfg_mul_shift);
`ifdef SDP_Y_MUL_PRELU_EN
        s1_prelu  <= cfg_mul_prelu;
`endif
        for (int i = 0; i < LANES; i++) begin
          s1_prod[i] <= mul[i];
          s1_raw[i]  <= lane_x[i];
        end
      end
    end
  end

  // S2: result register; held while downstream stalls.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else if (en2) begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_data <= s2_next;
    end
  end

  // Saturation events are counted as a beat enters S2; sticks at all-ones.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      sat_cnt <= '0;
    end else if (s1_valid && en2) begin
      sat_cnt <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_sdp_y_mul_stage.sv
// Directed bench for sdp_y_mul_stage with a queue-based reference model that
// is compared against the DUT on every cycle.
module tb_sdp_y_mul_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_mul_bypass;
  logic        cfg_mul_src;
  logic [15:0] cfg_mul_op;
  logic [5:0]  cfg_mul_shift;
  logic [31:0] sat_cnt;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  sdp_y_mul_stage_if #(.LANES(4), .OP_W(16)) bus ();

  sdp_y_mul_stage #(.LANES(4), .OP_W(16), .CNT_W(32)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .bus            (bus),
    .cfg_mul_bypass (cfg_mul_bypass),
    .cfg_mul_src    (cfg_mul_src),
    .cfg_mul_op     (cfg_mul_op),
    .cfg_mul_shift  (cfg_mul_shift),
    .sat_cnt        (sat_cnt)
  );

  typedef struct {
    logic [127:0] data;
    int           sat;
    int           age;
  } beat_t;

  beat_t  q[$];
  longint sat_popped = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic from the stage's rules.
  function automatic beat_t model_beat(input logic [127:0] x, input logic [63:0] ops,
                                       input logic src, input logic [15:0] cop,
                                       input logic [5:0] sh, input logic byp);
    beat_t b;
    b.data = '0;
    b.sat  = 0;
    b.age  = 1;
    for (int i = 0; i < 4; i++) begin
      logic signed [31:0] xv;
      logic signed [15:0] ov;
      longint xi, oi, p, r;
      int s;
      xv = x[32*i +: 32];
      ov = src ? ops[16*i +: 16] : cop;
      xi = xv;
      oi = ov;
      s  = (sh > 47) ? 47 : int'(sh);
      p  = xi * oi;
      if (byp) r = xi;
      else if (s > 0) r = (p + (longint'(1) << (s - 1))) >>> s;
      else r = p;
      if (!byp && r > 64'sd2147483647) begin
        r = 64'sd2147483647;
        b.sat++;
      end else if (!byp && r < -64'sd2147483648) begin
        r = -64'sd2147483648;
        b.sat++;
      end
      b.data[32*i +: 32] = r[31:0];
    end
    return b;
  endfunction

  function automatic logic [31:0] model_sat_cnt();
    longint t;
    t = sat_popped;
    if (q.size() > 0 && q[0].age >= 2) t += q[0].sat;
    return (t > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : t[31:0];
  endfunction

  // Per-cycle compare, then advance the model across the coming edge.
  always @(negedge clk) begin
    if (started) begin
      bit exp_ready, exp_acc, exp_out, vz;
      vz        = bus.chn_mul_out_rsc_vz;
      exp_ready = !rst && (q.size() < 2 || vz);
      exp_acc   = exp_ready && bus.chn_mul_in_rsc_vz && (!cfg_mul_src || bus.chn_mul_op_rsc_vz);
      exp_out   = !rst && q.size() > 0 && q[0].age >= 2;

      check("in_lz",  bus.chn_mul_in_rsc_lz,  cfg_mul_src ? exp_acc : exp_ready);
      check("op_lz",  bus.chn_mul_op_rsc_lz,  cfg_mul_src && exp_acc);
      check("out_lz", bus.chn_mul_out_rsc_lz, exp_out);
      check("triosy", bus.cfg_mul_rsc_triosy_lz, exp_out && vz);
      check("sat_cnt", sat_cnt, model_sat_cnt());
      if (exp_out) check("out_z", bus.chn_mul_out_rsc_z, q[0].data);

      if (rst) begin
        q.delete();
        sat_popped = 0;
      end else begin
        if (exp_out && vz) begin
          sat_popped += q[0].sat;
          void'(q.pop_front());
        end
        for (int i = 0; i < q.size(); i++) q[i].age = q[i].age + 1;
        if (exp_acc)
          q.push_back(model_beat(bus.chn_mul_in_rsc_z, bus.chn_mul_op_rsc_z, cfg_mul_src,
                                 cfg_mul_op, cfg_mul_shift, cfg_mul_bypass));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a beat and hold it until the stage takes it.
  task automatic send(input logic [127:0] d, input logic [63:0] o);
    bit got;
    got = 1'b0;
    bus.chn_mul_in_rsc_z  = d;
    bus.chn_mul_op_rsc_z  = o;
    bus.chn_mul_in_rsc_vz = 1'b1;
    bus.chn_mul_op_rsc_vz = 1'b1;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (bus.chn_mul_in_rsc_lz) got = 1'b1;
    end
    if (!got) check("send_timeout", 1'b0, 1'b1);
    tick();
    bus.chn_mul_in_rsc_vz = 1'b0;
    bus.chn_mul_op_rsc_vz = 1'b0;
  endtask

  beat_t pin;

  initial begin
    rst                    = 1'b1;
    cfg_mul_bypass         = 1'b0;
    cfg_mul_src            = 1'b0;
    cfg_mul_op             = 16'd3;
    cfg_mul_shift          = 6'd0;
    bus.chn_mul_in_rsc_z   = '0;
    bus.chn_mul_in_rsc_vz  = 1'b0;
    bus.chn_mul_op_rsc_z   = '0;
    bus.chn_mul_op_rsc_vz  = 1'b0;
    bus.chn_mul_out_rsc_vz = 1'b1;

    // Hand-computed values pinning the reference itself.
    pin = model_beat({32'd0, 32'd100, 32'hFFFF_FFFE, 32'd1}, '0, 1'b0, 16'd3, 6'd0, 1'b0);
    check("pin_mul", pin.data, {32'd0, 32'd300, 32'hFFFF_FFFA, 32'd3});
    pin = model_beat({32'd1, 32'd0, 32'h8000_0000, 32'h7FFF_FFFF}, '0, 1'b0, 16'h7FFF, 6'd0, 1'b0);
    check("pin_sat", pin.data, {32'h0000_7FFF, 32'd0, 32'h8000_0000, 32'h7FFF_FFFF});
    check("pin_sat_n", pin.sat, 2);
    pin = model_beat({32'hFFFF_FFFB, 32'd5, 32'hFFFF_FFFD, 32'd3}, '0, 1'b0, 16'd1, 6'd1, 1'b0);
    check("pin_round", pin.data, {32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'd2});
    pin = model_beat({32'd1, 32'd2, 32'd3, 32'h0000_0100}, '0, 1'b0, 16'd1, 6'd63, 1'b0);
    check("pin_clamp", pin.data, 128'd0);

    tick();
    started = 1'b1;
    tick();
    tick();
    check("reset_sat_cnt", sat_cnt, 32'd0);
    check("reset_out_lz", bus.chn_mul_out_rsc_lz, 1'b0);
    rst = 1'b0;
    tick();

    // Register operand, no shift.
    send({32'd0, 32'd100, 32'hFFFF_FFFE, 32'd1}, '0);
    tick();
    check("t1_out", bus.chn_mul_out_rsc_z, {32'd0, 32'd300, 32'hFFFF_FFFA, 32'd3});
    check("t1_sat_cnt", sat_cnt, 32'd0);
    repeat (2) tick();

    // Positive and negative saturation.
    cfg_mul_op = 16'h7FFF;
    send({32'd1, 32'd0, 32'h8000_0000, 32'h7FFF_FFFF}, '0);
    tick();
    check("t2_out", bus.chn_mul_out_rsc_z, {32'h0000_7FFF, 32'd0, 32'h8000_0000, 32'h7FFF_FFFF});
    check("t2_sat_cnt", sat_cnt, 32'd2);
    repeat (2) tick();

    // Round half up.
    cfg_mul_op    = 16'd1;
    cfg_mul_shift = 6'd1;
    send({32'hFFFF_FFFB, 32'd5, 32'hFFFF_FFFD, 32'd3}, '0);
    tick();
    check("t3_out", bus.chn_mul_out_rsc_z, {32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'd2});
    repeat (2) tick();

    // Operand channel: data waits for the operand.
    cfg_mul_src           = 1'b1;
    cfg_mul_shift         = 6'd0;
    bus.chn_mul_in_rsc_z  = {32'd1000, 32'd0, 32'hFFFF_FFF9, 32'd10};
    bus.chn_mul_in_rsc_vz = 1'b1;
    bus.chn_mul_op_rsc_vz = 1'b0;
    repeat (3) tick();
    check("t4_gap_lz", bus.chn_mul_in_rsc_lz, 1'b0);
    send({32'd1000, 32'd0, 32'hFFFF_FFF9, 32'd10}, {16'd2, 16'd2, 16'd2, 16'd2});
    tick();
    check("t4_out", bus.chn_mul_out_rsc_z, {32'd2000, 32'd0, 32'hFFFF_FFF2, 32'd20});
    repeat (2) tick();

    // Back-to-back stream with a 3-cycle downstream stall.
    cfg_mul_src   = 1'b0;
    cfg_mul_op    = 16'hFFFB;
    cfg_mul_shift = 6'd2;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send({32'(i * 7 - 3), 32'(-i * 1000), 32'(i + 1), 32'(i * 123456)}, '0);
      end
      begin
        repeat (3) tick();
        bus.chn_mul_out_rsc_vz = 1'b0;
        repeat (3) tick();
        bus.chn_mul_out_rsc_vz = 1'b1;
      end
    join
    repeat (4) tick();
    check("t5_drained", bus.chn_mul_out_rsc_lz, 1'b0);

    // Reset with two beats in flight, then a bypass beat.
    cfg_mul_op    = 16'h7FFF;
    cfg_mul_shift = 6'd0;
    send({4{32'h7FFF_FFFF}}, '0);
    send({4{32'h8000_0000}}, '0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_out_lz", bus.chn_mul_out_rsc_lz, 1'b0);
    check("t6_sat_cnt", sat_cnt, 32'd0);
    cfg_mul_bypass = 1'b1;
    send({32'h8000_0000, 32'h7FFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF}, '0);
    tick();
    check("t6_bypass", bus.chn_mul_out_rsc_z, {32'h8000_0000, 32'h7FFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF});
    repeat (3) tick();
    check("t6_bypass_sat", sat_cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
